// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RGB332 field layout and helpers for the derived timing points.
package vga_pkg;

    localparam int CLK_DIV  = 4;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int CNT_W = 10;
    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

    function automatic int span_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int sync_start(int act, int fp);
        return act + fp;
    endfunction

    function automatic int sync_end(int act, int fp, int sync);
        return act + fp + sync - 1;
    endfunction

    localparam int H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = sync_start(H_ACTIVE, H_FP);
    localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int VS_START = sync_start(V_ACTIVE, V_FP);
    localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

endpackage

// File: rtl/vga_timing_pix_en_gen.sv
// Clock-enable divider: one-clock pix_en pulse every DIV system clocks.
module pix_en_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div;

    assign pix_en = (div == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (pix_en)
            div <= '0;
        else
            div <= div + 1'b1;
    end
endmodule

// File: rtl/vga_timing.sv
// VGA beam counters, sync/active decode and the one-pixel output register stage.
module vga_timing #(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [vga_pkg::CNT_W-1:0] sx,
    output logic [vga_pkg::CNT_W-1:0] sy,
    output logic                      de,
    output logic                      pix_en,
    output logic                      frame_start,
    input  logic [vga_pkg::RGB_W-1:0] rgb_in,
    output logic [vga_pkg::R_W-1:0]   vga_r,
    output logic [vga_pkg::G_W-1:0]   vga_g,
    output logic [vga_pkg::B_W-1:0]   vga_b,
    output logic                      vga_hs,
    output logic                      vga_vs
);
    import vga_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic hs_raw;
    logic vs_raw;
    rgb_t pix;

    pix_en_gen #(.DIV(CLK_DIV)) u_pix_en (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx <= '0;
            sy <= '0;
        end else if (pix_en) begin
            if (sx == H_LAST) begin
                sx <= '0;
                sy <= (sy == V_LAST) ? '0 : sy + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end
        end
    end

    assign de          = (sx < H_ACT) && (sy < V_ACT);
    assign frame_start = pix_en && (sx == '0) && (sy == '0);
    assign hs_raw      = !((sx >= HS_LO) && (sx <= HS_HI));
    assign vs_raw      = !((sy >= VS_LO) && (sy <= VS_HI));

    // Colour and sync share one register stage so they leave the chip aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix    <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (pix_en) begin
            pix    <= de ? rgb_t'(rgb_in) : '0;
            vga_hs <= hs_raw;
            vga_vs <= vs_raw;
        end
    end

    assign vga_r = pix.r;
    assign vga_g = pix.g;
    assign vga_b = pix.b;
endmodule

// File: tb/tb_vga_timing.sv
// Bench: a default-timing instance with hand-computed checks and a shrunken-timing
// instance checked every cycle against an arithmetic beam model under random colour.
module tb_vga_timing;

    localparam int SD   = 3;
    localparam int SHA  = 20, SHF = 3, SHS = 4, SHB = 3;
    localparam int SVA  = 6,  SVF = 2, SVS = 2, SVB = 2;
    localparam int SHT  = SHA + SHF + SHS + SHB;
    localparam int SVT  = SVA + SVF + SVS + SVB;

    logic clk = 1'b0;
    logic rst_n;

    logic [9:0] d_sx, d_sy;
    logic       d_de, d_pix_en, d_fs, d_hs, d_vs;
    logic [7:0] d_rgb;
    logic [2:0] d_r, d_g;
    logic [1:0] d_b;

    logic [9:0] s_sx, s_sy;
    logic       s_de, s_pix_en, s_fs, s_hs, s_vs;
    logic [7:0] s_rgb;
    logic [2:0] s_r, s_g;
    logic [1:0] s_b;

    int checks = 0;
    int errors = 0;

    vga_timing dut_d (
        .clk(clk), .rst_n(rst_n), .sx(d_sx), .sy(d_sy), .de(d_de),
        .pix_en(d_pix_en), .frame_start(d_fs), .rgb_in(d_rgb),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs)
    );

    vga_timing #(
        .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .sx(s_sx), .sy(s_sy), .de(s_de),
        .pix_en(s_pix_en), .frame_start(s_fs), .rgb_in(s_rgb),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Random colour for the small instance, changed just after each edge.
    initial begin
        s_rgb = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            s_rgb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        end
    end

    // Beam model: after k clocks out of reset, k/SD pixels have elapsed.
    int         k;
    logic [7:0] e_rgb;
    logic       e_hs, e_vs;
    int         m_n, m_px, m_py;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; e_rgb = 8'h00; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            if (k % SD == SD - 1) begin
                m_n  = k / SD;
                m_px = m_n % SHT;
                m_py = (m_n / SHT) % SVT;
                e_rgb = (m_px < SHA && m_py < SVA) ? s_rgb : 8'h00;
                e_hs  = !(m_px >= SHA + SHF && m_px < SHA + SHF + SHS);
                e_vs  = !(m_py >= SVA + SVF && m_py < SVA + SVF + SVS);
            end
            k++;
        end
    end

    int         c_n, c_px, c_py;
    logic       c_pe;
    always @(negedge clk) begin
        c_n  = k / SD;
        c_px = c_n % SHT;
        c_py = (c_n / SHT) % SVT;
        c_pe = (k % SD == SD - 1);
        chk("model", {s_sx, s_sy, s_de, s_pix_en, s_fs, s_r, s_g, s_b, s_hs, s_vs},
            {10'(c_px), 10'(c_py), (c_px < SHA && c_py < SVA), c_pe,
             (c_pe && c_px == 0 && c_py == 0), e_rgb, e_hs, e_vs});
    end

    int  first, gap, t656, tlow, hs_cnt, ff_cnt, zr_cnt, vs_cnt, per;
    bit  found;

    initial begin
        rst_n = 1'b0;
        d_rgb = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_default", {d_sx, d_sy, d_de, d_pix_en, d_fs, d_r, d_g, d_b, d_hs, d_vs},
            {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        #2 rst_n = 1'b1;

        first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (d_pix_en) begin first = i + 1; break; end
        end
        chk("first_pix_en_clk", first, 4);
        chk("first_frame_start", d_fs, 1'b1);
        gap = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (d_pix_en) begin gap = i; break; end
        end
        chk("pix_en_period", gap, 4);

        found = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (d_pix_en && d_sx == 10'd799 && d_sy == 10'd0) begin found = 1; break; end
        end
        chk("reach_799_0", found, 1'b1);
        @(negedge clk);
        chk("line_wrap", {d_sx, d_sy}, {10'd0, 10'd1});

        // One full default line starting at sx=0, sy=1.
        t656 = -1; tlow = -1; hs_cnt = 0; ff_cnt = 0; zr_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            if (t656 < 0 && d_sx == 10'd656) t656 = i;
            if (tlow < 0 && !d_hs) tlow = i;
            if (!d_hs) hs_cnt++;
            if (!d_vs) vs_cnt++;
            if ({d_r, d_g, d_b} == 8'hFF) ff_cnt++;
            if ({d_r, d_g, d_b} == 8'h00) zr_cnt++;
            @(negedge clk);
        end
        chk("hs_low_clk", hs_cnt, 384);
        chk("hs_lag_clk", tlow - t656, 4);
        chk("rgb_ff_clk", ff_cnt, 2560);
        chk("rgb_zero_clk", zr_cnt, 640);
        chk("vs_low_line1", vs_cnt, 0);
        chk("after_line_pos", {d_sx, d_sy}, {10'd0, 10'd2});

        found = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (s_fs) begin found = 1; break; end
        end
        chk("small_fs_found", found, 1'b1);
        per = 0; vs_cnt = 0; hs_cnt = 0;
        for (int i = 1; i <= 2500; i++) begin
            if (!s_vs) vs_cnt++;
            if (!s_hs) hs_cnt++;
            @(negedge clk);
            if (s_fs) begin per = i; break; end
        end
        chk("small_frame_period", per, 1080);
        chk("small_vs_low_clk", vs_cnt, 180);
        chk("small_hs_low_clk", hs_cnt, 144);

        found = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (s_sx == 10'd15 && s_sy == 10'd3) begin found = 1; break; end
        end
        chk("small_mid_found", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_small", {s_sx, s_sy, s_de, s_pix_en, s_fs, s_r, s_g, s_b, s_hs, s_vs},
            {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        chk("async_rst_default", {d_sx, d_sy, d_de, d_pix_en, d_fs, d_r, d_g, d_b, d_hs, d_vs},
            {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3 * 1080 + 20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
